path_check: RTL and testbench

PATH_CHECK -- requirements
Module: path_check

---
 rtl/path_check.sv | 184 ++++++++++++++++++
 tb/tb_path_check.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/path_check.sv
// path_check: tracks a maze walk supplied as a burst of direction beats.
// Each path starts at (START_X, START_Y) and is checked for out-of-bounds
// moves and revisited cells. At the end it is checked for arrival at
// (MAZE_SIZE, MAZE_SIZE). Results are presented with a one-cycle strobe.
//
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset
//   in_valid  - direction beat qualifier, one contiguous burst per path
//   in        - direction: 0 right (x+1), 1 down (y+1), 2 left (x-1), 3 up (y-1)
//   out_valid - one-cycle result strobe
//   steps     - accepted beats, saturating at 511
//   turns     - beats whose code differs from the previous beat, saturating at 255
//   pos_x/y   - final tracked position
//   err       - 0 ok, 1 out-of-bounds, 2 revisit, 3 ended off target (sticky)
module path_check #(
  parameter int unsigned MAZE_SIZE = 17,
  parameter int unsigned START_X   = 1,
  parameter int unsigned START_Y   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [1:0] in,
  output logic       out_valid,
  output logic [8:0] steps,
  output logic [7:0] turns,
  output logic [4:0] pos_x,
  output logic [4:0] pos_y,
  output logic [1:0] err
);

  localparam int unsigned Cells    = MAZE_SIZE * MAZE_SIZE;
  localparam int unsigned IdxW     = $clog2(Cells);
  localparam int unsigned StartIdx = (START_Y - 1) * MAZE_SIZE + (START_X - 1);
  localparam logic [Cells-1:0] StartMask = {{(Cells - 1){1'b0}}, 1'b1} << StartIdx;

  typedef enum logic [2:0] {
    StIdle   = 3'b001,
    StTrack  = 3'b010,
    StReport = 3'b100
  } state_e;

  state_e           r_state, w_state_next;
  logic             r_out_valid, w_out_valid_next;
  logic [8:0]       r_steps, w_steps_next;
  logic [7:0]       r_turns, w_turns_next;
  logic [4:0]       r_x, r_y, w_x_next, w_y_next;
  logic [1:0]       r_err, w_err_next;
  logic [1:0]       r_prev, w_prev_next;
  logic [Cells-1:0] r_visited, w_visited_next;

  // Beat evaluation; a path's first beat is applied on top of freshly loaded start values.
  logic             w_first;
  logic [4:0]       w_base_x, w_base_y;
  logic [8:0]       w_base_steps;
  logic [7:0]       w_base_turns;
  logic [1:0]       w_base_err;
  logic [Cells-1:0] w_base_visited;
  logic [5:0]       w_cand_x, w_cand_y;
  logic             w_in_bounds;
  logic [IdxW-1:0]  w_cell_idx;
  logic [4:0]       w_beat_x, w_beat_y;
  logic [8:0]       w_beat_steps;
  logic [7:0]       w_beat_turns;
  logic [1:0]       w_beat_err;
  logic [Cells-1:0] w_beat_visited;

  always_comb begin
    w_first        = (r_state == StIdle);
    w_base_x       = w_first ? 5'(START_X) : r_x;
    w_base_y       = w_first ? 5'(START_Y) : r_y;
    w_base_steps   = w_first ? 9'd0 : r_steps;
    w_base_turns   = w_first ? 8'd0 : r_turns;
    w_base_err     = w_first ? 2'd0 : r_err;
    w_base_visited = w_first ? StartMask : r_visited;

    // 6-bit candidate so that 0 and MAZE_SIZE+1 are both visible as out of range
    w_cand_x = {1'b0, w_base_x};
    w_cand_y = {1'b0, w_base_y};
    unique case (in)
      2'd0: w_cand_x = w_cand_x + 6'd1;
      2'd1: w_cand_y = w_cand_y + 6'd1;
      2'd2: w_cand_x = w_cand_x - 6'd1;
      2'd3: w_cand_y = w_cand_y - 6'd1;
      default: ;
    endcase

    w_in_bounds = (w_cand_x >= 6'd1) && (w_cand_x <= 6'(MAZE_SIZE)) &&
                  (w_cand_y >= 6'd1) && (w_cand_y <= 6'(MAZE_SIZE));
    w_cell_idx  = '0;
    if (w_in_bounds) begin
      w_cell_idx = IdxW'((32'(w_cand_y) - 32'd1) * MAZE_SIZE + 32'(w_cand_x) - 32'd1);
    end

    w_beat_x       = w_base_x;
    w_beat_y       = w_base_y;
    w_beat_err     = w_base_err;
    w_beat_visited = w_base_visited;
    if (!w_in_bounds) begin
      if (w_base_err == 2'd0) w_beat_err = 2'd1;
    end else begin
      w_beat_x = w_cand_x[4:0];
      w_beat_y = w_cand_y[4:0];
      if (w_base_visited[w_cell_idx]) begin
        if (w_base_err == 2'd0) w_beat_err = 2'd2;
      end else begin
        w_beat_visited[w_cell_idx] = 1'b1;
      end
    end

    w_beat_steps = (w_base_steps == 9'd511) ? w_base_steps : w_base_steps + 9'd1;
    w_beat_turns = w_base_turns;
    if (!w_first && (in != r_prev) && (w_base_turns != 8'd255)) begin
      w_beat_turns = w_base_turns + 8'd1;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_out_valid_next = 1'b0;
    w_steps_next     = r_steps;
    w_turns_next     = r_turns;
    w_x_next         = r_x;
    w_y_next         = r_y;
    w_err_next       = r_err;
    w_prev_next      = r_prev;
    w_visited_next   = r_visited;
    unique case (r_state)
      StIdle, StTrack: begin
        if (in_valid) begin
          w_state_next   = StTrack;
          w_steps_next   = w_beat_steps;
          w_turns_next   = w_beat_turns;
          w_x_next       = w_beat_x;
          w_y_next       = w_beat_y;
          w_err_next     = w_beat_err;
          w_prev_next    = in;
          w_visited_next = w_beat_visited;
        end else if (r_state == StTrack) begin
          w_state_next     = StReport;
          w_out_valid_next = 1'b1;
          if ((r_err == 2'd0) && ((r_x != 5'(MAZE_SIZE)) || (r_y != 5'(MAZE_SIZE)))) begin
            w_err_next = 2'd3;
          end
        end
      end
      StReport: w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_out_valid <= 1'b0;
      r_steps     <= '0;
      r_turns     <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_err       <= '0;
      r_prev      <= '0;
      r_visited   <= '0;
    end else begin
      r_state     <= w_state_next;
      r_out_valid <= w_out_valid_next;
      r_steps     <= w_steps_next;
      r_turns     <= w_turns_next;
      r_x         <= w_x_next;
      r_y         <= w_y_next;
      r_err       <= w_err_next;
      r_prev      <= w_prev_next;
      r_visited   <= w_visited_next;
    end
  end

  assign out_valid = r_out_valid;
  assign steps     = r_steps;
  assign turns     = r_turns;
  assign pos_x     = r_x;
  assign pos_y     = r_y;
  assign err       = r_err;

endmodule

// File: tb/tb_path_check.sv
// tb_path_check: directed-vector bench for path_check with hand-computed results.
module tb_path_check;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [1:0] in;
  logic       out_valid;
  logic [8:0] steps;
  logic [7:0] turns;
  logic [4:0] pos_x, pos_y;
  logic [1:0] err;

  int n_checks = 0;
  int n_errors = 0;
  logic [1:0] codes[$];

  always #5 clk = ~clk;

  path_check dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in        (in),
    .out_valid (out_valid),
    .steps     (steps),
    .turns     (turns),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [1:0] code, input int n);
    for (int i = 0; i < n; i++) codes.push_back(code);
  endtask

  // Drive the queued beats back to back, then drop in_valid.
  task automatic play();
    foreach (codes[i]) begin
      @(negedge clk);
      in_valid = 1'b1;
      in       = codes[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
    in       = 2'd0;
  endtask

  // Strobe must appear exactly one cycle after in_valid low is sampled, last one cycle,
  // and the results must hold afterwards.
  task automatic expect_report(input string tag, input int e_steps, input int e_turns,
                               input int e_x, input int e_y, input int e_err);
    @(negedge clk);
    check({tag, " out_valid"}, 32'(out_valid), 1);
    check({tag, " steps"}, 32'(steps), e_steps);
    check({tag, " turns"}, 32'(turns), e_turns);
    check({tag, " pos_x"}, 32'(pos_x), e_x);
    check({tag, " pos_y"}, 32'(pos_y), e_y);
    check({tag, " err"}, 32'(err), e_err);
    @(negedge clk);
    check({tag, " strobe width"}, 32'(out_valid), 0);
    check({tag, " steps hold"}, 32'(steps), e_steps);
    check({tag, " err hold"}, 32'(err), e_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in       = 2'd0;
    repeat (2) @(negedge clk);
    check("reset out_valid", 32'(out_valid), 0);
    check("reset steps", 32'(steps), 0);
    check("reset turns", 32'(turns), 0);
    check("reset pos_x", 32'(pos_x), 0);
    check("reset pos_y", 32'(pos_y), 0);
    check("reset err", 32'(err), 0);
    rst = 1'b0;
    @(negedge clk);

    // Diagonal-corner legal path
    codes.delete(); fill(2'd0, 16); fill(2'd1, 16);
    play(); expect_report("legal", 32, 1, 17, 17, 0);

    // Off-grid first beat; error sticks through later legal beats
    codes.delete(); codes = '{2'd3, 2'd0, 2'd0, 2'd1};
    play(); expect_report("oob_first", 4, 2, 3, 2, 1);

    // Reversal onto the start cell
    codes.delete(); codes = '{2'd0, 2'd2};
    play(); expect_report("revisit", 2, 1, 1, 1, 2);

    // Ends off target
    codes.delete(); codes = '{2'd0, 2'd0, 2'd1};
    play(); expect_report("off_target", 3, 1, 3, 2, 3);

    // Burst of one beat
    codes.delete(); codes = '{2'd0};
    play(); expect_report("single", 1, 0, 2, 1, 3);

    // Walk off the far edge
    codes.delete(); fill(2'd0, 17);
    play(); expect_report("oob_edge", 17, 0, 17, 1, 1);

    // Counter saturation: 600 alternating beats, 599 turns
    codes.delete();
    for (int i = 0; i < 600; i++) codes.push_back((i % 2 == 0) ? 2'd0 : 2'd2);
    play(); expect_report("saturate", 511, 255, 1, 1, 2);

    // Reset mid-path aborts without a strobe
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in       = 2'd0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    check("abort steps", 32'(steps), 0);
    check("abort pos_x", 32'(pos_x), 0);
    check("abort err", 32'(err), 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort no strobe", 32'(out_valid), 0);
    end
    codes.delete(); fill(2'd0, 16); fill(2'd1, 16);
    play(); expect_report("after_abort", 32, 1, 17, 17, 0);

    // Back-to-back paths; the second shares (17,17) with the first
    codes.delete(); fill(2'd0, 16); fill(2'd1, 16);
    play(); expect_report("pair_a", 32, 1, 17, 17, 0);
    codes.delete(); fill(2'd1, 16); fill(2'd0, 16);
    play(); expect_report("pair_b", 32, 1, 17, 17, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
